uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receive stage, the downstream counterpart of the transmitter: it decodes a line driven by the transmitter, or by an external device, into words for the host side. It uses the same frame configuration inputs and the same clock-divisor semantics as the transmitter, so one configuration register set drives both directions. Received words are presented on a valid/ready interface with per-word error flags.

## Interface
Parameters:
- CLOCK_DIVISOR_WIDTH, 24, width of clockDivisor.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rx  in  1  serial line, asynchronous to clk; idle high.
- dataBits  in  2  data bit count = dataBits + 5.
- hasParity  in  1  frame carries a parity bit.
- parityMode  in  2  00 space, 11 mark, 10 even, 01 odd.
- extraStopBit  in  1  two stop bits instead of one.
- clockDivisor  in  CLOCK_DIVISOR_WIDTH  H = clockDivisor+1; bit period T = 2H clk cycles.
- data  out  8  received word, LSB-aligned, unused upper bits 0.
- valid  out  1  data and flags hold a word.
- ready  in  1  consumer accepts the word when valid&ready.
- parityError  out  1  parity sample mismatched the expected value.
- frameError  out  1  a stop-bit sample was 0.
- overrun  out  1  at least one later frame was dropped while this word was held.

## Operation
- rx passes through a 2-flop synchronizer, both flops reset to 1. All logic below uses the synchronized value rxs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on rxs (previous 1, current 0) at cycle t0 does three things: latches dataBits, hasParity, parityMode, extraStopBit and clockDivisor; clears the bit counter; enters START.
- START: sample at t0+H. If rxs=0, enter DATA. If rxs=1, treat it as a false start, return to IDLE and produce no output.
- DATA: sample n = dataBits+5 bits, LSB first, at t0+H+kT for k=1..n. Shift each sample into a shift register. After bit n, go to PARITY if hasParity, otherwise STOP.
- PARITY: sample at the next bit time. Expected value is 0 for space, 1 for mark, XOR of the n data bits for even, and the inverse of that XOR for odd. parityError = sample ≠ expected.
- STOP: sample one stop bit, or two if extraStopBit, at consecutive bit times. frameError is set if any stop sample is 0. After the last stop sample, deliver the word and return to IDLE at mid-stop-bit, so the next start edge can be detected.
- Delivery when valid=0 or valid&ready this cycle: load data, parityError and frameError; set valid; set overrun=0.
- Delivery when valid=1 and ready=0: discard the new frame; data and flags are unchanged; set overrun=1.
- Acceptance (valid&ready with no simultaneous delivery): clear valid, parityError, frameError and overrun.
- A line that stays low (break) yields a word with frameError=1. The receiver re-arms only after rxs returns to 1 and falls again.

## Timing
- Reset values: data=0, valid=0, parityError=0, frameError=0, overrun=0, state IDLE, synchronizer=1.
- An asynchronous rst mid-frame aborts the frame with no output. The first rising clk edge after release may already detect a start.
- The synchronizer adds 2 cycles from an rx transition to rxs.
- valid rises one cycle after the last stop sample (registered output).
- Counter width is CLOCK_DIVISOR_WIDTH+1 bits, so T = 2H does not overflow when clockDivisor is at its maximum.
- clockDivisor=0 is legal: H=1, T=2.
- Configuration inputs may change at any time and take effect only at the next start edge.

## Structure
- Shared package uart_pkg holds:
  - parity mode constants SPACE/ODD/EVEN/MARK;
  - the data-bit offset 5;
  - the RX state encoding.
- One sub-module, uart_parity_calc: combinational expected-parity computation from data, dataBits and parityMode. It is reusable by the transmitter.
- Synchronizer and bit timing stay inline.

## Test plan
- 8N1, clockDivisor=3 (T=8), ready=1, frame 0xA5 → data=0xA5, valid high for one cycle at t0+77, all flags 0.
- 7E1, frame 0x35 (four ones) sent with parity bit 1 → data=0x35, parityError=1, frameError=0. Repeat with parity bit 0 → parityError=0.
- rx pulsed low for 2 cycles, clockDivisor=3 → no valid; a clean 0x3C frame immediately after is received correctly.
- 5O2, frame 0x1F, second stop bit driven 0 → data=0x1F, frameError=1. With extraStopBit=0 the same waveform gives frameError=0.
- ready=0, frames 0x11 then 0x22 → data=0x11, overrun=1. After ready pulse: valid=0, overrun=0. Frame 0x33 then received with overrun=0.
- rst asserted mid-DATA → all outputs 0 asynchronously; after release, frame 0x5A → data=0x5A with no flags.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the transmit and receive stages.
//               Holds the parity mode encoding, the data-bit count offset
//               and the receive state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Parity mode encoding, as carried on the parityMode configuration input
   localparam logic [1:0] PARITY_SPACE = 2'b00;
   localparam logic [1:0] PARITY_ODD   = 2'b01;
   localparam logic [1:0] PARITY_EVEN  = 2'b10;
   localparam logic [1:0] PARITY_MARK  = 2'b11;

   // Number of data bits in a frame is dataBits + DATA_BIT_OFFSET
   localparam logic [2:0] DATA_BIT_OFFSET = 3'd5;

   // Receive state encoding
   localparam logic [2:0] RX_IDLE   = 3'd0;
   localparam logic [2:0] RX_START  = 3'd1;
   localparam logic [2:0] RX_DATA   = 3'd2;
   localparam logic [2:0] RX_PARITY = 3'd3;
   localparam logic [2:0] RX_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// ============================================================================
// Module      : uart_parity_calc
// Description : Combinational expected-parity computation for a UART frame.
//               Only the low dataBits+5 bits of data take part in the XOR.
// Ports       : data       in  8  data word, LSB-aligned
//               dataBits   in  2  data bit count = dataBits + 5
//               parityMode in  2  00 space, 11 mark, 10 even, 01 odd
//               parity     out 1  expected parity bit value
// Revision    : 1.0 - initial release
// ============================================================================
module uart_parity_calc
   import uart_pkg::*;
(
   input  logic [7:0] data,
   input  logic [1:0] dataBits,
   input  logic [1:0] parityMode,
   output logic       parity
);

   logic [7:0] w_mask;
   logic       w_xor;

   always_comb begin
      // dataBits=3 keeps all 8 bits, dataBits=0 keeps the low 5
      w_mask = 8'hFF >> (2'd3 - dataBits);
      w_xor  = ^(data & w_mask);
      parity = 1'b0;
      case (parityMode)
         PARITY_SPACE: parity = 1'b0;
         PARITY_MARK:  parity = 1'b1;
         PARITY_EVEN:  parity = w_xor;
         PARITY_ODD:   parity = ~w_xor;
         default:      parity = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Serial-to-parallel UART receive stage. Decodes 5..8 data bits
//               with optional parity and one or two stop bits, presenting each
//               word on a valid/ready interface with per-word error flags.
// Ports       : clk, rst (async, active-high)
//               rx                    serial line, idle high
//               dataBits, hasParity, parityMode, extraStopBit, clockDivisor
//                                     frame configuration, latched per frame
//               data, valid, ready    received word handshake
//               parityError, frameError, overrun   per-word status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLOCK_DIVISOR_WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rx,
   input  logic [1:0]                     dataBits,
   input  logic                           hasParity,
   input  logic [1:0]                     parityMode,
   input  logic                           extraStopBit,
   input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
   output logic [7:0]                     data,
   output logic                           valid,
   input  logic                           ready,
   output logic                           parityError,
   output logic                           frameError,
   output logic                           overrun
);

   localparam logic [CLOCK_DIVISOR_WIDTH:0] c_cntOne = {{CLOCK_DIVISOR_WIDTH{1'b0}}, 1'b1};

   // Synchronizer and edge detection
   logic r_rxMeta;
   logic r_rxs;
   logic r_rxPrev;

   // Frame state
   logic [2:0]                     r_state;
   logic [CLOCK_DIVISOR_WIDTH:0]   r_cnt;
   logic [2:0]                     r_bitCnt;
   logic                           r_stopCnt;
   logic [7:0]                     r_shift;
   logic                           r_parSample;
   logic                           r_frameErr;

   // Configuration latched at the start edge
   logic [1:0]                     r_dataBits;
   logic                           r_hasParity;
   logic [1:0]                     r_parityMode;
   logic                           r_extraStop;
   logic [CLOCK_DIVISOR_WIDTH-1:0] r_div;

   logic                           w_fall;
   logic                           w_tick;
   logic [CLOCK_DIVISOR_WIDTH:0]   w_period;
   logic [2:0]                     w_lastBit;
   logic [7:0]                     w_word;
   logic                           w_expParity;
   logic                           w_parityErr;
   logic                           w_frameErr;
   logic                           w_lastStop;
   logic                           w_deliver;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rxMeta <= 1'b1;
         r_rxs    <= 1'b1;
         r_rxPrev <= 1'b1;
      end else begin
         r_rxMeta <= rx;
         r_rxs    <= r_rxMeta;
         r_rxPrev <= r_rxs;
      end
   end

   always_comb begin
      w_fall      = r_rxPrev & ~r_rxs;
      w_tick      = (r_cnt == '0);
      // Full bit period minus one: 2H-1 = 2*clockDivisor+1
      w_period    = {r_div, 1'b1};
      w_lastBit   = {1'b0, r_dataBits} + DATA_BIT_OFFSET - 3'd1;
      // LSB-first samples enter at the top; right-align the n received bits
      w_word      = r_shift >> (2'd3 - r_dataBits);
      w_parityErr = r_hasParity & (r_parSample != w_expParity);
      w_frameErr  = r_frameErr | ~r_rxs;
      w_lastStop  = (r_stopCnt == r_extraStop);
      w_deliver   = (r_state == RX_STOP) & w_tick & w_lastStop;
   end

   uart_parity_calc u_parity (
      .data       (w_word),
      .dataBits   (r_dataBits),
      .parityMode (r_parityMode),
      .parity     (w_expParity)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= RX_IDLE;
         r_cnt        <= '0;
         r_bitCnt     <= 3'd0;
         r_stopCnt    <= 1'b0;
         r_shift      <= 8'd0;
         r_parSample  <= 1'b0;
         r_frameErr   <= 1'b0;
         r_dataBits   <= 2'd0;
         r_hasParity  <= 1'b0;
         r_parityMode <= 2'd0;
         r_extraStop  <= 1'b0;
         r_div        <= '0;
      end else if (r_state == RX_IDLE) begin
         if (w_fall) begin
            r_dataBits   <= dataBits;
            r_hasParity  <= hasParity;
            r_parityMode <= parityMode;
            r_extraStop  <= extraStopBit;
            r_div        <= clockDivisor;
            // First sample lands H cycles after the edge: count H-1 down to 0
            r_cnt        <= {1'b0, clockDivisor};
            r_bitCnt     <= 3'd0;
            r_shift      <= 8'd0;
            r_state      <= RX_START;
         end
      end else if (!w_tick) begin
         r_cnt <= r_cnt - c_cntOne;
      end else begin
         r_cnt <= w_period;
         case (r_state)
            RX_START: begin
               // A line back high at mid-start-bit was only a glitch
               r_state <= r_rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
               r_shift  <= {r_rxs, r_shift[7:1]};
               r_bitCnt <= r_bitCnt + 3'd1;
               if (r_bitCnt == w_lastBit) begin
                  r_stopCnt  <= 1'b0;
                  r_frameErr <= 1'b0;
                  r_state    <= r_hasParity ? RX_PARITY : RX_STOP;
               end
            end
            RX_PARITY: begin
               r_parSample <= r_rxs;
               r_state     <= RX_STOP;
            end
            RX_STOP: begin
               r_frameErr <= w_frameErr;
               r_stopCnt  <= 1'b1;
               // Re-arm at mid-stop-bit so the next start edge is not missed
               if (w_lastStop) begin
                  r_state <= RX_IDLE;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data        <= 8'd0;
         valid       <= 1'b0;
         parityError <= 1'b0;
         frameError  <= 1'b0;
         overrun     <= 1'b0;
      end else if (w_deliver && (!valid || ready)) begin
         data        <= w_word;
         valid       <= 1'b1;
         parityError <= w_parityErr;
         frameError  <= w_frameErr;
         overrun     <= 1'b0;
      end else if (w_deliver) begin
         // Held word is kept; the new frame is dropped
         overrun     <= 1'b1;
      end else if (valid && ready) begin
         valid       <= 1'b0;
         parityError <= 1'b0;
         frameError  <= 1'b0;
         overrun     <= 1'b0;
      end
   end

endmodule
`default_nettype wire
